// File: rtl/pmu_pkg.sv
// pmu_pkg: shared types and constants for the SAIL power management unit.
//   pmu_state_e : per-channel sequencer state
//   TMR_W       : width of the per-channel delay timer
//   *_MIN/*_MAX : legal ranges for the pmu_ctrl delay/count parameters
package pmu_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_PWRUP = 3'd1,
    ST_ON    = 3'd2,
    ST_PDN   = 3'd3,
    ST_OFF   = 3'd4
  } pmu_state_e;

  localparam int TMR_W = 8;

  localparam int NUM_CH_MIN   = 1;
  localparam int NUM_CH_MAX   = 8;
  localparam int IDLE_CNT_MIN = 1;
  localparam int IDLE_CNT_MAX = 255;
  localparam int PU_DLY_MIN   = 1;
  localparam int PU_DLY_MAX   = 255;
  localparam int PD_DLY_MIN   = 1;
  localparam int PD_DLY_MAX   = 255;

endpackage

// File: rtl/pmu_chan.sv
// pmu_chan: one clock channel sequencer (RST -> PWRUP -> ON -> PDN -> OFF)
// with its own delay timer. All outputs are registered from the next state.
// Optional feature macro: PMU_AUTOWAKE_EN (wake from PDN/OFF).
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   halt_seen   : shared registered halt indication
//   mask        : 1 = channel may be shut down by halt
//   wake_req    : level-sampled wake request
//   wake_acc    : comb, wake accepted this cycle (clears shared counter)
//   powerup     : oscillator power-up
//   enable      : oscillator output enable
//   ch_on       : channel is in ON
module pmu_chan
  import pmu_pkg::*;
#(
  parameter int PU_DLY = 4,
  parameter int PD_DLY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic halt_seen,
  input  logic mask,
  input  logic wake_req,
  output logic wake_acc,
  output logic powerup,
  output logic enable,
  output logic ch_on
);

  localparam logic [TMR_W-1:0] PU_LD = TMR_W'(PU_DLY - 1);
  localparam logic [TMR_W-1:0] PD_LD = TMR_W'(PD_DLY - 1);

  pmu_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pu_q, pu_d;
  logic             en_q, en_d;
  logic             wake_ok;

`ifdef PMU_AUTOWAKE_EN
  assign wake_ok = wake_req;
`else
  // One-shot shutdown: OFF is terminal until reset.
  logic unused_wake;
  assign unused_wake = wake_req;
  assign wake_ok     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    wake_acc = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_PWRUP;
        tmr_d   = PU_LD;
      end
      ST_PWRUP: begin
        if (tmr_q == '0) state_d = ST_ON;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_ON: begin
        if (halt_seen && mask) begin
          state_d = ST_PDN;
          tmr_d   = PD_LD;
        end
      end
      ST_PDN: begin
        // Wake beats the pending power-down; oscillator stays powered.
        if (wake_ok) begin
          wake_acc = 1'b1;
          state_d  = ST_PWRUP;
          tmr_d    = PU_LD;
        end else if (tmr_q == '0) begin
          state_d  = ST_OFF;
        end else begin
          tmr_d    = tmr_q - 1'b1;
        end
      end
      ST_OFF: begin
        if (wake_ok) begin
          wake_acc = 1'b1;
          state_d  = ST_PWRUP;
          tmr_d    = PU_LD;
        end
      end
      default: begin
        state_d = ST_RST;
        tmr_d   = '0;
      end
    endcase
    // enable implies powerup by construction: ON is a subset of the pu states.
    pu_d = (state_d == ST_PWRUP) || (state_d == ST_ON) || (state_d == ST_PDN);
    en_d = (state_d == ST_ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      tmr_q   <= '0;
      pu_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pu_q    <= pu_d;
      en_q    <= en_d;
    end
  end

  assign powerup = pu_q;
  assign enable  = en_q;
  assign ch_on   = en_q;

endmodule

// File: rtl/pmu_ctrl.sv
// pmu_ctrl: SAIL power management unit. Shared halt detector on the
// monitored data word plus NUM_CH independent channel sequencers.
// Optional feature macro: PMU_AUTOWAKE_EN (wake_req honoured in PDN/OFF).
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   mon_data       : monitored word, mon_valid qualifies it
//   ch_mask        : per channel, 1 = may be shut down by halt
//   wake_req       : per channel wake request
//   clkhf_powerup  : per channel oscillator power-up
//   clkhf_enable   : per channel oscillator output enable
//   ch_on          : per channel ON indication
//   halt_seen      : registered halt detection
module pmu_ctrl
  import pmu_pkg::*;
#(
  parameter int                NUM_CH   = 2,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] HALT_VAL = DATA_W'('h1000),
  parameter int                IDLE_CNT = 2,
  parameter int                PU_DLY   = 4,
  parameter int                PD_DLY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mon_data,
  input  logic              mon_valid,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] wake_req,
  output logic [NUM_CH-1:0] clkhf_powerup,
  output logic [NUM_CH-1:0] clkhf_enable,
  output logic [NUM_CH-1:0] ch_on,
  output logic              halt_seen
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_nch
    $error("pmu_ctrl: NUM_CH out of range");
  end
  if (IDLE_CNT < IDLE_CNT_MIN || IDLE_CNT > IDLE_CNT_MAX) begin : g_bad_idle
    $error("pmu_ctrl: IDLE_CNT out of range");
  end
  if (PU_DLY < PU_DLY_MIN || PU_DLY > PU_DLY_MAX) begin : g_bad_pu
    $error("pmu_ctrl: PU_DLY out of range");
  end
  if (PD_DLY < PD_DLY_MIN || PD_DLY > PD_DLY_MAX) begin : g_bad_pd
    $error("pmu_ctrl: PD_DLY out of range");
  end

  localparam int               CNT_W   = $clog2(IDLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CNT);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halt_q, halt_d;
  logic [NUM_CH-1:0] wake_acc;

  // Accepted wake clears ahead of any increment on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (|wake_acc) begin
      cnt_d = '0;
    end else if (mon_valid) begin
      if (mon_data != HALT_VAL)  cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
    halt_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      halt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      halt_q <= halt_d;
    end
  end

  assign halt_seen = halt_q;

  pmu_chan #(
    .PU_DLY (PU_DLY),
    .PD_DLY (PD_DLY)
  ) u_chan [NUM_CH-1:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .halt_seen (halt_q),
    .mask      (ch_mask),
    .wake_req  (wake_req),
    .wake_acc  (wake_acc),
    .powerup   (clkhf_powerup),
    .enable    (clkhf_enable),
    .ch_on     (ch_on)
  );

endmodule

// File: tb/tb_pmu_ctrl.sv
// tb_pmu_ctrl: table-driven vectors, hand sequences for the multi-cycle
// corners, and a randomized run against a delay-based reference model.
module tb_pmu_ctrl;

  localparam int          NUM_CH   = 2;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] HALT     = 32'h1000;
  localparam int          IDLE_CNT = 2;
  localparam int          PU_DLY   = 4;
  localparam int          PD_DLY   = 2;
`ifdef PMU_AUTOWAKE_EN
  localparam bit AW = 1'b1;
`else
  localparam bit AW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] mon_data;
  logic              mon_valid;
  logic [NUM_CH-1:0] ch_mask, wake_req;
  logic [NUM_CH-1:0] clkhf_powerup, clkhf_enable, ch_on;
  logic              halt_seen;

  always #5 clk = ~clk;

  pmu_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .HALT_VAL(HALT),
    .IDLE_CNT(IDLE_CNT), .PU_DLY(PU_DLY), .PD_DLY(PD_DLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mon_data(mon_data), .mon_valid(mon_valid),
    .ch_mask(ch_mask), .wake_req(wake_req), .clkhf_powerup(clkhf_powerup),
    .clkhf_enable(clkhf_enable), .ch_on(ch_on), .halt_seen(halt_seen)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each channel is described by its visible outputs, a
  // "going down" flag and the number of edges left until the pending change.
  bit              m_started;
  bit [NUM_CH-1:0] m_pu, m_en, m_down;
  int              m_left [NUM_CH];
  int              m_cnt;
  bit              m_halt;

  task automatic model_reset();
    m_started = 0; m_pu = '0; m_en = '0; m_down = '0;
    m_cnt = 0; m_halt = 0;
    for (int i = 0; i < NUM_CH; i++) m_left[i] = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d,
                            input bit [NUM_CH-1:0] m, input bit [NUM_CH-1:0] w);
    bit [NUM_CH-1:0] acc;
    bit old_halt;
    old_halt = m_halt;
    for (int i = 0; i < NUM_CH; i++)
      acc[i] = AW && w[i] && m_started && !m_en[i] && (m_down[i] || !m_pu[i]);
    if (acc != 0)  m_cnt = 0;
    else if (v)    m_cnt = (d == HALT) ? ((m_cnt < IDLE_CNT) ? m_cnt + 1 : IDLE_CNT) : 0;
    m_halt = (m_cnt == IDLE_CNT);
    for (int i = 0; i < NUM_CH; i++) begin
      if (!m_started || acc[i]) begin
        m_pu[i] = 1; m_down[i] = 0; m_left[i] = PU_DLY;
      end else if (m_en[i]) begin
        if (old_halt && m[i]) begin
          m_en[i] = 0; m_down[i] = 1; m_left[i] = PD_DLY;
        end
      end else if (m_pu[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          if (m_down[i]) begin m_pu[i] = 0; m_down[i] = 0; end
          else m_en[i] = 1;
        end
      end
    end
    m_started = 1;
  endtask

  // Drive at the falling edge, let the rising edge sample, check at the next
  // falling edge.
  task automatic apply(input bit v, input logic [31:0] d, input bit [NUM_CH-1:0] m,
                       input bit [NUM_CH-1:0] w, input bit cmp_model);
    mon_valid = v; mon_data = d; ch_mask = m; wake_req = w;
    @(posedge clk);
    model_step(v, d, m, w);
    @(negedge clk);
    if (cmp_model) begin
      chk("model_halt", {31'b0, halt_seen}, {31'b0, m_halt});
      chk("model_pu",   32'(clkhf_powerup), 32'(m_pu));
      chk("model_en",   32'(clkhf_enable),  32'(m_en));
      chk("model_on",   32'(ch_on),         32'(m_en));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mon_valid = 0; mon_data = '0; ch_mask = '0; wake_req = '0;
    model_reset();
    @(negedge clk);
    chk("rst_outputs", {25'b0, halt_seen, clkhf_powerup, clkhf_enable, ch_on}, 32'h0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit              v;
    logic [31:0]     d;
    bit [NUM_CH-1:0] m;
    bit [NUM_CH-1:0] w;
    bit              h;
    bit [NUM_CH-1:0] pu;
    bit [NUM_CH-1:0] en;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(bit v, logic [31:0] d, bit [1:0] m, bit [1:0] w,
                              bit h, bit [1:0] pu, bit [1:0] en);
    vec_t r;
    r.v = v; r.d = d; r.m = m; r.w = w; r.h = h; r.pu = pu; r.en = en;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; mon_valid = 0; mon_data = '0; ch_mask = '0; wake_req = '0;

    // Row n = inputs sampled at edge n+1 after reset release, outputs after it.
    for (int e = 0; e < 4; e++) tbl[e] = mk(0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00);
    tbl[4]  = mk(0, 0,        2'b00, 2'b00, 0, 2'b11, 2'b11);
    tbl[5]  = mk(1, HALT,     2'b01, 2'b00, 0, 2'b11, 2'b11);
    tbl[6]  = mk(1, HALT,     2'b01, 2'b00, 1, 2'b11, 2'b11);
    tbl[7]  = mk(0, 0,        2'b01, 2'b00, 1, 2'b11, 2'b10);
    tbl[8]  = mk(0, 0,        2'b01, 2'b00, 1, 2'b11, 2'b10);
    tbl[9]  = mk(0, 0,        2'b01, 2'b00, 1, 2'b10, 2'b10);
    tbl[10] = mk(1, 32'h0FFC, 2'b01, 2'b00, 0, 2'b10, 2'b10);
    tbl[11] = mk(1, HALT,     2'b00, 2'b00, 0, 2'b10, 2'b10);
    tbl[12] = mk(1, 32'h0FFC, 2'b00, 2'b00, 0, 2'b10, 2'b10);
    tbl[13] = mk(1, HALT,     2'b00, 2'b00, 0, 2'b10, 2'b10);
    tbl[14] = mk(0, HALT,     2'b00, 2'b00, 0, 2'b10, 2'b10);
    tbl[15] = mk(1, HALT,     2'b00, 2'b00, 1, 2'b10, 2'b10);
    if (AW) begin
      tbl[16] = mk(0, 0, 2'b00, 2'b01, 0, 2'b11, 2'b10);
      for (int e = 17; e < 20; e++) tbl[e] = mk(0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b10);
      tbl[20] = mk(0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b11);
    end else begin
      tbl[16] = mk(0, 0, 2'b00, 2'b01, 1, 2'b10, 2'b10);
      for (int e = 17; e < 21; e++) tbl[e] = mk(0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b10);
    end

    // Table-driven phase: reset release, halt shutdown, counter rules, wake.
    do_reset();
    for (int e = 0; e < 21; e++) begin
      apply(tbl[e].v, tbl[e].d, tbl[e].m, tbl[e].w, 1'b0);
      chk($sformatf("tbl%0d_halt", e + 1), {31'b0, halt_seen}, {31'b0, tbl[e].h});
      chk($sformatf("tbl%0d_pu", e + 1),   32'(clkhf_powerup), 32'(tbl[e].pu));
      chk($sformatf("tbl%0d_en", e + 1),   32'(clkhf_enable),  32'(tbl[e].en));
      chk($sformatf("tbl%0d_on", e + 1),   32'(ch_on),         32'(tbl[e].en));
    end

    // Wake during the first PDN cycle: powerup must not drop.
    do_reset();
    for (int e = 1; e <= 5; e++) apply(0, 0, 2'b01, 2'b00, 1'b1);
    apply(1, HALT, 2'b01, 2'b00, 1'b1);                 // edge 6
    apply(1, HALT, 2'b01, 2'b00, 1'b1);                 // edge 7, halt_seen
    apply(0, 0, 2'b01, 2'b00, 1'b1);                    // edge 8, PDN
    chk("pdn_en0", 32'(clkhf_enable[0]), 32'd0);
    for (int e = 9; e <= 13; e++) begin
      apply(0, 0, 2'b01, (e == 9) ? 2'b01 : 2'b00, 1'b1);
      chk($sformatf("pdnwake_pu0_e%0d", e), 32'(clkhf_powerup[0]),
          32'((AW || e < 10) ? 1 : 0));
      chk($sformatf("pdnwake_en0_e%0d", e), 32'(clkhf_enable[0]),
          32'((AW && e == 13) ? 1 : 0));
    end

    // Reset pulsed during PWRUP: outputs drop without waiting for an edge.
    do_reset();
    apply(0, 0, 2'b11, 2'b00, 1'b1);
    apply(0, 0, 2'b11, 2'b00, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {25'b0, halt_seen, clkhf_powerup, clkhf_enable, ch_on}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      apply(0, 0, 2'b11, 2'b00, 1'b1);
      chk($sformatf("rerun_en_e%0d", e), 32'(clkhf_enable), 32'((e >= 5) ? 3 : 0));
    end

    // Randomized run against the model, with periodic resets.
    for (int blk = 0; blk < 4; blk++) begin
      bit [NUM_CH-1:0] rm;
      do_reset();
      rm = 2'($urandom);
      for (int c = 0; c < 150; c++) begin
        bit              rv;
        logic [31:0]     rd;
        bit [NUM_CH-1:0] rw;
        if ($urandom_range(0, 19) == 0) rm = 2'($urandom);
        rv = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) != 0) ? HALT : $urandom;
        rw = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
        apply(rv, rd, rm, rw, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
